// File: rtl/mips_mem_pkg.sv
// Shared definitions for the main-memory responder: FSM states and default timing/geometry.
package mips_mem_pkg;

  localparam int DEFAULT_LATENCY     = 10;
  localparam int DEFAULT_BLOCK_WORDS = 4;
  localparam int LAT_CNT_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_RBURST = 3'd2,
    ST_WBURST = 3'd3,
    ST_WACK   = 3'd4
  } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Word-wide storage with one synchronous write port and one registered read port.
module mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory model serving cache block refills and writebacks.
module main_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int LATENCY     = DEFAULT_LATENCY,
  parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] wdata,
  input  logic        wdata_valid,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        rdata_last,
  output logic        wr_done,
  output logic        busy
);

  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam int BEAT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  localparam logic [BEAT_W-1:0]    LAST_BEAT  = BEAT_W'(BLOCK_WORDS - 1);
  localparam logic [LAT_CNT_W-1:0] LAST_WAIT  = LAT_CNT_W'(LATENCY - 1);
  localparam logic [AW-1:0]        BLOCK_MASK = ~AW'(BLOCK_WORDS - 1);

  mem_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0] lat_q, lat_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [AW-1:0]        base_q, base_d;
  logic                 write_q, write_d;

  logic [AW-1:0]     req_word;
  logic [BEAT_W-1:0] rd_beat;
  logic [AW-1:0]     mem_raddr;
  logic [AW-1:0]     mem_waddr;
  logic              mem_we;
  logic [31:0]       mem_rdata;
  logic              unused_addr_bits;

  // Upper address bits wrap the array; byte offset is irrelevant for word access.
  assign req_word         = req_addr[AW+1:2];
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    base_d  = base_q;
    write_d = write_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_WAIT;
          lat_d   = '0;
          beat_d  = '0;
          base_d  = req_word & BLOCK_MASK;
          write_d = req_write;
        end
      end
      ST_WAIT: begin
        if (lat_q == LAST_WAIT) begin
          state_d = write_q ? ST_WBURST : ST_RBURST;
          lat_d   = '0;
          beat_d  = '0;
        end else begin
          lat_d = lat_q + LAT_CNT_W'(1);
        end
      end
      ST_RBURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ST_WBURST: begin
        if (wdata_valid) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_WACK;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_WACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      write_q <= write_d;
    end
  end

  // Read address runs one word ahead so the registered read lines up with each beat.
  assign rd_beat   = (state_q == ST_RBURST) ? (beat_q + BEAT_W'(1)) : '0;
  assign mem_raddr = base_q + AW'(rd_beat);
  assign mem_waddr = base_q + AW'(beat_q);
  assign mem_we    = (state_q == ST_WBURST) && wdata_valid;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem_array (
    .clk      (clk),
    .wr_en_i  (mem_we),
    .wr_addr_i(mem_waddr),
    .wr_data_i(wdata),
    .rd_addr_i(mem_raddr),
    .rd_data_o(mem_rdata)
  );

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign rdata_valid = (state_q == ST_RBURST);
  assign rdata_last  = rdata_valid && (beat_q == LAST_BEAT);
  assign rdata       = rdata_valid ? mem_rdata : '0;
  assign wr_done     = (state_q == ST_WACK);

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: refill/writeback timing, gaps, wrap, busy requests, reset.
module tb_main_mem_responder;

  localparam int LAT = 4;
  localparam int BW  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] wdata;
  logic        wdata_valid;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        rdata_last;
  logic        wr_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic        cap_valid [24];
  logic        cap_last  [24];
  logic        cap_busy  [24];
  logic [31:0] cap_data  [24];
  logic        cap_wd    [16];

  always #5 clk = ~clk;

  main_mem_responder #(
    .LATENCY    (LAT),
    .BLOCK_WORDS(BW),
    .DEPTH_WORDS(1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .wdata      (wdata),
    .wdata_valid(wdata_valid),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .rdata_last (rdata_last),
    .wr_done    (wr_done),
    .busy       (busy)
  );

  initial begin
    #100000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Present a request and return just after the edge that accepted it.
  task automatic issue_req(input logic [31:0] addr, input logic wr);
    logic was_ready;
    int   n;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    n = 0;
    do begin
      was_ready = req_ready;
      @(posedge clk); #1;
      n++;
    end while (!was_ready && n < 50);
    if (!was_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout addr=%h actual=not accepted required=accepted", addr);
    end
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic do_refill(input logic [31:0] addr);
    issue_req(addr, 1'b0);
    for (int j = 0; j < 12; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      cap_valid[j] = rdata_valid;
      cap_last[j]  = rdata_last;
      cap_busy[j]  = busy;
      cap_data[j]  = rdata;
    end
    $display("refill    addr=%h words=%h %h %h %h", addr,
             cap_data[LAT], cap_data[LAT+1], cap_data[LAT+2], cap_data[LAT+3]);
  endtask

  // Junk with wdata_valid=1 is driven while idle/waiting; it must not be written.
  task automatic do_writeback(input logic [31:0] addr, input logic [31:0] dbase,
                              input logic [7:0] pat, input int ncyc);
    int widx;
    wdata_valid = 1'b1;
    wdata       = 32'hBAD0_0000;
    issue_req(addr, 1'b1);
    repeat (LAT) begin
      @(posedge clk); #1;
    end
    widx = 0;
    for (int i = 0; i < ncyc; i++) begin
      wdata_valid = pat[i];
      if (pat[i]) begin
        wdata = dbase + 32'(widx);
        widx++;
      end else begin
        wdata = 32'hBAD1_0000 + 32'(i);
      end
      @(posedge clk); #1;
      cap_wd[i] = wr_done;
    end
    wdata_valid = 1'b0;
    wdata       = '0;
    $display("writeback addr=%h data=%h.. pattern=%b cycles=%0d", addr, dbase, pat, ncyc);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy actual=%b required=0", busy); end
    total++; if (rdata_valid !== 1'b0) begin bad++; $display("FAIL reset_rvalid actual=%b required=0", rdata_valid); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata actual=%h required=0", rdata); end
    total++; if (rdata_last !== 1'b0) begin bad++; $display("FAIL reset_rlast actual=%b required=0", rdata_last); end
    total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL reset_wr_done actual=%b required=0", wr_done); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready actual=%b required=1", req_ready); end
    $display("reset     released");
  endtask

  task automatic test_refill_timing;
    logic        ev, el, eb;
    logic [31:0] ed;
    do_writeback(32'h40, 32'h0000_1010, 8'h0F, 4);
    do_refill(32'h40);
    for (int j = 0; j < 12; j++) begin
      ev = (j >= LAT) && (j < LAT + BW);
      el = (j == LAT + BW - 1);
      eb = (j < LAT + BW);
      ed = ev ? (32'h0000_1010 + 32'(j - LAT)) : 32'h0;
      total++; if (cap_valid[j] !== ev) begin bad++; $display("FAIL timing_valid j=%0d actual=%b required=%b", j, cap_valid[j], ev); end
      total++; if (cap_last[j] !== el) begin bad++; $display("FAIL timing_last j=%0d actual=%b required=%b", j, cap_last[j], el); end
      total++; if (cap_busy[j] !== eb) begin bad++; $display("FAIL timing_busy j=%0d actual=%b required=%b", j, cap_busy[j], eb); end
      total++; if (cap_data[j] !== ed) begin bad++; $display("FAIL timing_data j=%0d actual=%h required=%h", j, cap_data[j], ed); end
    end
  endtask

  task automatic test_writeback_no_gaps;
    logic [31:0] ed;
    do_writeback(32'h80, 32'h0000_00A0, 8'h0F, 4);
    for (int i = 0; i < 4; i++) begin
      total++; if (cap_wd[i] !== (i == 3)) begin bad++; $display("FAIL wb_done_cycle i=%0d actual=%b required=%b", i, cap_wd[i], (i == 3)); end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wb_wack_busy actual=%b required=1", busy); end
    @(posedge clk); #1;
    total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL wb_done_pulse actual=%b required=0", wr_done); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL wb_idle_ready actual=%b required=1", req_ready); end
    do_refill(32'h80);
    for (int k = 0; k < BW; k++) begin
      ed = 32'h0000_00A0 + 32'(k);
      total++; if (cap_data[LAT+k] !== ed || cap_valid[LAT+k] !== 1'b1) begin bad++; $display("FAIL wb_readback k=%0d actual=%h required=%h", k, cap_data[LAT+k], ed); end
    end
  endtask

  task automatic test_refill_offset;
    logic [31:0] ed;
    do_refill(32'h4C);
    for (int k = 0; k < BW; k++) begin
      ed = 32'h0000_1010 + 32'(k);
      total++; if (cap_data[LAT+k] !== ed) begin bad++; $display("FAIL offset_data k=%0d actual=%h required=%h", k, cap_data[LAT+k], ed); end
    end
    // 0x1043: word index 0x410 wraps to 0x10 in a 1024-word array; byte offset ignored.
    do_refill(32'h1043);
    for (int k = 0; k < BW; k++) begin
      ed = 32'h0000_1010 + 32'(k);
      total++; if (cap_data[LAT+k] !== ed) begin bad++; $display("FAIL wrap_data k=%0d actual=%h required=%h", k, cap_data[LAT+k], ed); end
    end
  endtask

  task automatic test_writeback_gaps;
    logic [31:0] ed;
    do_writeback(32'hC0, 32'h0000_00C0, 8'b0101_1001, 7);
    for (int i = 0; i < 7; i++) begin
      total++; if (cap_wd[i] !== (i == 6)) begin bad++; $display("FAIL gap_done_cycle i=%0d actual=%b required=%b", i, cap_wd[i], (i == 6)); end
    end
    do_refill(32'hC0);
    for (int k = 0; k < BW; k++) begin
      ed = 32'h0000_00C0 + 32'(k);
      total++; if (cap_data[LAT+k] !== ed) begin bad++; $display("FAIL gap_readback k=%0d actual=%h required=%h", k, cap_data[LAT+k], ed); end
    end
  endtask

  task automatic test_req_while_busy;
    logic        ev, er;
    logic [31:0] ed;
    issue_req(32'h80, 1'b0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'hC0;
    // First block beats at j=4..7, held request accepted at j=8->9, its beats at j=13..16.
    for (int j = 0; j < 19; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      if (j == 9) req_valid = 1'b0;
      ev = ((j >= 4) && (j <= 7)) || ((j >= 13) && (j <= 16));
      er = (j == 8) || (j >= 17);
      if (j >= 4 && j <= 7) ed = 32'h0000_00A0 + 32'(j - 4);
      else if (j >= 13 && j <= 16) ed = 32'h0000_00C0 + 32'(j - 13);
      else ed = 32'h0;
      total++; if (req_ready !== er) begin bad++; $display("FAIL busy_ready j=%0d actual=%b required=%b", j, req_ready, er); end
      total++; if (rdata_valid !== ev) begin bad++; $display("FAIL busy_valid j=%0d actual=%b required=%b", j, rdata_valid, ev); end
      total++; if (rdata !== ed) begin bad++; $display("FAIL busy_data j=%0d actual=%h required=%h", j, rdata, ed); end
    end
    $display("held-req  first=80 second=c0 done");
  endtask

  task automatic test_reset_mid_refill;
    issue_req(32'h40, 1'b0);
    repeat (LAT + 1) begin
      @(posedge clk); #1;
    end
    total++; if (rdata_valid !== 1'b1 || rdata !== 32'h0000_1011) begin bad++; $display("FAIL midrst_beat2 actual=%b/%h required=1/00001011", rdata_valid, rdata); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (rdata_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid actual=%b required=0", rdata_valid); end
    total++; if (rdata_last !== 1'b0) begin bad++; $display("FAIL midrst_last actual=%b required=0", rdata_last); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy actual=%b required=0", busy); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready actual=%b required=1", req_ready); end
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      total++; if (rdata_valid !== 1'b0 || rdata_last !== 1'b0) begin bad++; $display("FAIL midrst_quiet j=%0d actual=%b%b required=00", j, rdata_valid, rdata_last); end
    end
    $display("mid-reset refill abandoned");
    do_refill(32'h40);
    total++; if (cap_data[LAT] !== 32'h0000_1010) begin bad++; $display("FAIL midrst_mem_kept actual=%h required=00001010", cap_data[LAT]); end
  endtask

  initial begin
    rst         = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    wdata       = '0;
    wdata_valid = 1'b0;
    test_reset();
    test_refill_timing();
    test_writeback_no_gaps();
    test_refill_offset();
    test_writeback_gaps();
    test_req_while_busy();
    test_reset_mid_refill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
